// File: rtl/sub_bytes_if.sv
// Bundle of the SubBytes stage's data path signals.
// The producer (register read) side uses master. The SubBytes stage uses slave.
interface sub_bytes_if #(
   parameter int regSize = 32,
   parameter int vecSize = 4
);
   logic                             in_valid;
   logic [vecSize-1:0][regSize-1:0]  state;
   logic [vecSize-1:0][regSize-1:0]  new_state;
   logic                             out_valid;

   modport master (
      output in_valid,
      output state,
      input  new_state,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  state,
      output new_state,
      output out_valid
   );
endinterface

// File: rtl/sub_bytes.sv
// AES SubBytes stage: every byte of the vecSize x regSize state is replaced by
// its forward S-box value. The result is registered, which gives one pipeline
// stage of latency. The output holds its value when no valid input arrives.
module sub_bytes #(
   parameter int regSize = 32,
   parameter int vecSize = 4
) (
   input  logic       clk,
   input  logic       rst,
   sub_bytes_if.slave bus
);

   localparam int NUM_LANES = vecSize * regSize / 8;
   localparam int STATE_W   = vecSize * regSize;

   // Forward S-box. Row r and column c hold SBOX(16*r + c).
   localparam logic [7:0] SBOX_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Flat view of the state. Lane gi covers bits 8*gi+7:8*gi, so lane
   // (i*regSize/8 + j) is byte j of word i. Word and byte order are kept.
   logic [STATE_W-1:0]               flat_in;
   logic [STATE_W-1:0]               flat_sub;
   logic [vecSize-1:0][regSize-1:0]  new_state_d;
   logic [vecSize-1:0][regSize-1:0]  new_state_q;
   logic                             out_valid_d;
   logic                             out_valid_q;

   assign flat_in = bus.state;

   // One independent S-box lookup per byte lane. No lane depends on another.
   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign flat_sub[gi*8 +: 8] = SBOX_TABLE[flat_in[gi*8 +: 8]];
      end
   endgenerate

   // Capture a new result only on a valid input; otherwise hold the result and drop valid.
   always_comb begin
      new_state_d = new_state_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         new_state_d = flat_sub;
         out_valid_d = 1'b1;
      end
   end

   // Output register. Reset clears it immediately, without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         new_state_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         new_state_q <= new_state_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.new_state = new_state_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sub_bytes.sv
// Testbench for sub_bytes: directed table, S-box sweep, hold and reset cases.
module tb_sub_bytes;

   typedef logic [3:0][31:0] state_t;

   typedef struct {
      string  name;
      logic   vld;
      state_t st;
      state_t exp_st;
      logic   exp_v;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [7:0] sbox_ref [256];
   vec_t vecs [6];

   sub_bytes_if #(.regSize(32), .vecSize(4)) bus ();

   sub_bytes #(.regSize(32), .vecSize(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         if (a[7]) a = (a << 1) ^ 8'h1b;
         else      a = a << 1;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Reference S-box: multiplicative inverse followed by the affine transform.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   task automatic check_state(input string name, input state_t act, input state_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s new_state got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_valid(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s out_valid got %b expected %b", name, act, exp);
      end
   endtask

   function automatic state_t splat(input logic [7:0] b);
      return {16{b}};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      for (int k = 0; k < 256; k++) sbox_ref[k] = sbox_calc(8'(k));

      // Hand-computed vectors, applied in order (hold rows depend on the row before).
      vecs[0] = '{"directed", 1'b1,
                  {32'h3f3f7f7f, 32'h0f0f1f1f, 32'h03030707, 32'h00000101},
                  {32'h7575d2d2, 32'h7676c0c0, 32'h7b7bc5c5, 32'h63637c7c}, 1'b1};
      vecs[1] = '{"hold", 1'b0,
                  {32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff},
                  {32'h7575d2d2, 32'h7676c0c0, 32'h7b7bc5c5, 32'h63637c7c}, 1'b0};
      vecs[2] = '{"all_ff", 1'b1,
                  {32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff},
                  {32'h16161616, 32'h16161616, 32'h16161616, 32'h16161616}, 1'b1};
      vecs[3] = '{"all_53", 1'b1,
                  {32'h53535353, 32'h53535353, 32'h53535353, 32'h53535353},
                  {32'hedededed, 32'hedededed, 32'hedededed, 32'hedededed}, 1'b1};
      vecs[4] = '{"lanes", 1'b1,
                  {32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203},
                  {32'hfed7ab76, 32'h3001672b, 32'hf26b6fc5, 32'h637c777b}, 1'b1};
      vecs[5] = '{"idle_hold", 1'b0,
                  {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000},
                  {32'hfed7ab76, 32'h3001672b, 32'hf26b6fc5, 32'h637c777b}, 1'b0};

      // Reset from time zero.
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.state = '0;
      #2;
      check_state("reset_init", bus.new_state, '0);
      check_valid("reset_init", bus.out_valid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Idle after release: output stays cleared.
      @(posedge clk); #1;
      check_state("post_reset_idle", bus.new_state, '0);
      check_valid("post_reset_idle", bus.out_valid, 1'b0);

      // Table-driven vectors.
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = vecs[i].vld;
         bus.state    = vecs[i].st;
         @(posedge clk); #1;
         check_state(vecs[i].name, bus.new_state, vecs[i].exp_st);
         check_valid(vecs[i].name, bus.out_valid, vecs[i].exp_v);
         $display("vec %s in=%h vld=%b out=%h ov=%b", vecs[i].name, vecs[i].st, vecs[i].vld,
                  bus.new_state, bus.out_valid);
      end

      // Asynchronous reset between edges clears the held result at once.
      #2;
      rst = 1'b1;
      #1;
      check_state("async_reset", bus.new_state, '0);
      check_valid("async_reset", bus.out_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back sweep over every byte value.
      for (int k = 0; k < 256; k++) begin
         bus.in_valid = 1'b1;
         bus.state    = splat(8'(k));
         @(posedge clk); #1;
         check_state($sformatf("sweep_%02h", k), bus.new_state, splat(sbox_ref[k]));
         check_valid($sformatf("sweep_%02h", k), bus.out_valid, 1'b1);
      end

      // Reset in the middle of a stream.
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.state    = splat(8'(8'h40 + k));
         @(posedge clk); #1;
         check_state("stream_pre", bus.new_state, splat(sbox_ref[8'h40 + k]));
         if (k == 1) begin
            #2;
            rst = 1'b1;
            #1;
            check_state("mid_reset_now", bus.new_state, '0);
            check_valid("mid_reset_now", bus.out_valid, 1'b0);
            // Valid input during reset is discarded.
            @(posedge clk); #1;
            check_state("mid_reset_edge", bus.new_state, '0);
            check_valid("mid_reset_edge", bus.out_valid, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            check_state("release_idle", bus.new_state, '0);
            check_valid("release_idle", bus.out_valid, 1'b0);
         end
      end

      // The loop above resumed after release: the last value must be the result.
      check_valid("stream_resume", bus.out_valid, 1'b1);
      bus.in_valid = 1'b0;
      bus.state    = splat(8'h00);
      @(posedge clk); #1;
      check_state("stream_end_hold", bus.new_state, splat(sbox_ref[8'h43]));
      check_valid("stream_end_hold", bus.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
